// File: rtl/de10lite_gsensor_spi_responder.sv
// ADXL345-style SPI mode-3 responder for the DE10-Lite G-sensor port, oversampled on clk_i.
// Define GSENSOR_OFFSET_EN to add the OFSX/Y/Z offset registers at 0x1E-0x20.
module de10lite_gsensor_spi_responder #(
    parameter logic [7:0] DEVID       = 8'hE5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               sclk_i,
    input  logic               cs_ni,
    input  logic               sdi_i,
    output logic               sdo_o,
    output logic               sdo_oe_o,
    output logic [1:0]         int_o,
    input  logic signed [15:0] axis_x_i,
    input  logic signed [15:0] axis_y_i,
    input  logic signed [15:0] axis_z_i,
    input  logic               axis_valid_i
);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_WDATA, S_RDATA} state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_sdi_sync;
    logic                   r_sclk_d, r_cs_d;
    logic                   w_sclk, w_cs, w_sdi;
    logic                   w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;

    state_t      r_state;
    logic [2:0]  r_bitcnt;
    logic [6:0]  r_shift;
    logic [7:0]  r_tx;
    logic [5:0]  r_addr;
    logic        r_mb;
    logic        r_sdo, r_oe;
    logic [7:0]  w_cmd;
    logic [5:0]  w_addr_next, w_rd_addr;
    logic [7:0]  w_rd_data;
    logic        w_wr, w_rd37_done;

    logic [7:0]  r_bw_rate, r_power_ctl, r_int_en, r_int_map, r_data_format;
    logic [15:0] r_data_x, r_data_y, r_data_z;
    logic [15:0] r_pend_x, r_pend_y, r_pend_z;
    logic        r_pend_v, r_dr;
    logic [1:0]  r_int;
    logic        w_strobe, w_direct, w_lat;
    logic [15:0] w_src_x, w_src_y, w_src_z, w_lat_x, w_lat_y, w_lat_z;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sclk_sync <= '1;
            r_cs_sync   <= '1;
            r_sdi_sync  <= '0;
            r_sclk_d    <= 1'b1;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_i};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_ni};
            r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0], sdi_i};
            r_sclk_d    <= w_sclk;
            r_cs_d      <= w_cs;
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_sdi       = r_sdi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;
    assign w_cs_fall   = ~w_cs & r_cs_d;
    assign w_cs_rise   = w_cs & ~r_cs_d;

    assign w_cmd       = {r_shift, w_sdi};
    assign w_addr_next = r_mb ? r_addr + 6'd1 : r_addr;
    // In CMD the byte being decoded is the address; afterwards it is the next byte's address
    assign w_rd_addr   = (r_state == S_CMD) ? w_cmd[5:0] : w_addr_next;
    assign w_wr        = (r_state == S_WDATA) & ~w_cs & w_sclk_rise & (r_bitcnt == 3'd7);
    assign w_rd37_done = (r_state == S_RDATA) & ~w_cs & w_sclk_rise & (r_bitcnt == 3'd7)
                         & (r_addr == 6'h37);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_tx     <= '0;
            r_addr   <= '0;
            r_mb     <= 1'b0;
            r_sdo    <= 1'b0;
            r_oe     <= 1'b0;
        end else if (w_cs) begin
            r_state  <= S_IDLE;
            r_bitcnt <= '0;
            r_sdo    <= 1'b0;
            r_oe     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cs_fall) begin
                        r_state  <= S_CMD;
                        r_bitcnt <= '0;
                    end
                end
                S_CMD: begin
                    if (w_sclk_rise) begin
                        r_shift  <= w_cmd[6:0];
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            r_mb   <= w_cmd[6];
                            r_addr <= w_cmd[5:0];
                            if (w_cmd[7]) begin
                                r_state <= S_RDATA;
                                r_oe    <= 1'b1;
                                r_tx    <= w_rd_data;
                            end else begin
                                r_state <= S_WDATA;
                            end
                        end
                    end
                end
                S_WDATA: begin
                    if (w_sclk_rise) begin
                        r_shift  <= w_cmd[6:0];
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) r_addr <= w_addr_next;
                    end
                end
                S_RDATA: begin
                    if (w_sclk_fall) begin
                        r_sdo <= r_tx[7];
                        r_tx  <= {r_tx[6:0], 1'b0};
                    end else if (w_sclk_rise) begin
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            r_addr <= w_addr_next;
                            r_tx   <= w_rd_data;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef GSENSOR_OFFSET_EN
    logic [7:0] r_ofs_x, r_ofs_y, r_ofs_z;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ofs_x <= '0;
            r_ofs_y <= '0;
            r_ofs_z <= '0;
        end else if (w_wr) begin
            if (r_addr == 6'h1E) r_ofs_x <= w_cmd;
            if (r_addr == 6'h1F) r_ofs_y <= w_cmd;
            if (r_addr == 6'h20) r_ofs_z <= w_cmd;
        end
    end

    // Offset LSB is 4 data LSBs; sum wraps modulo 2^16
    assign w_lat_x = w_src_x + {{6{r_ofs_x[7]}}, r_ofs_x, 2'b00};
    assign w_lat_y = w_src_y + {{6{r_ofs_y[7]}}, r_ofs_y, 2'b00};
    assign w_lat_z = w_src_z + {{6{r_ofs_z[7]}}, r_ofs_z, 2'b00};
`else
    assign w_lat_x = w_src_x;
    assign w_lat_y = w_src_y;
    assign w_lat_z = w_src_z;
`endif

    always_comb begin
        w_rd_data = 8'h00;
        case (w_rd_addr)
            6'h00: w_rd_data = DEVID;
`ifdef GSENSOR_OFFSET_EN
            6'h1E: w_rd_data = r_ofs_x;
            6'h1F: w_rd_data = r_ofs_y;
            6'h20: w_rd_data = r_ofs_z;
`endif
            6'h2C: w_rd_data = r_bw_rate;
            6'h2D: w_rd_data = r_power_ctl;
            6'h2E: w_rd_data = r_int_en;
            6'h2F: w_rd_data = r_int_map;
            6'h30: w_rd_data = {r_dr, 7'b0};
            6'h31: w_rd_data = r_data_format;
            6'h32: w_rd_data = r_data_x[7:0];
            6'h33: w_rd_data = r_data_x[15:8];
            6'h34: w_rd_data = r_data_y[7:0];
            6'h35: w_rd_data = r_data_y[15:8];
            6'h36: w_rd_data = r_data_z[7:0];
            6'h37: w_rd_data = r_data_z[15:8];
            default: w_rd_data = 8'h00;
        endcase
    end

    // Samples arriving during a transfer wait in the pending buffer until cs releases
    assign w_strobe = axis_valid_i & r_power_ctl[3];
    assign w_direct = w_strobe & w_cs;
    assign w_lat    = w_direct | (w_cs_rise & r_pend_v);
    assign w_src_x  = w_direct ? axis_x_i : r_pend_x;
    assign w_src_y  = w_direct ? axis_y_i : r_pend_y;
    assign w_src_z  = w_direct ? axis_z_i : r_pend_z;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_bw_rate     <= 8'h0A;
            r_power_ctl   <= '0;
            r_int_en      <= '0;
            r_int_map     <= '0;
            r_data_format <= '0;
            r_data_x      <= '0;
            r_data_y      <= '0;
            r_data_z      <= '0;
            r_pend_x      <= '0;
            r_pend_y      <= '0;
            r_pend_z      <= '0;
            r_pend_v      <= 1'b0;
            r_dr          <= 1'b0;
            r_int         <= 2'b00;
        end else begin
            if (w_wr) begin
                case (r_addr)
                    6'h2C: r_bw_rate     <= w_cmd;
                    6'h2D: r_power_ctl   <= w_cmd;
                    6'h2E: r_int_en      <= w_cmd;
                    6'h2F: r_int_map     <= w_cmd;
                    6'h31: r_data_format <= w_cmd;
                    default: ;
                endcase
            end
            if (w_strobe & ~w_cs) begin
                r_pend_x <= axis_x_i;
                r_pend_y <= axis_y_i;
                r_pend_z <= axis_z_i;
                r_pend_v <= 1'b1;
            end else if (w_lat) begin
                r_pend_v <= 1'b0;
            end
            if (w_lat) begin
                r_data_x <= w_lat_x;
                r_data_y <= w_lat_y;
                r_data_z <= w_lat_z;
            end
            if (w_lat)            r_dr <= 1'b1;
            else if (w_rd37_done) r_dr <= 1'b0;
            r_int <= {r_dr & r_int_en[7] & r_int_map[7], r_dr & r_int_en[7] & ~r_int_map[7]};
        end
    end

    assign sdo_o    = r_sdo;
    assign sdo_oe_o = r_oe;
    assign int_o    = r_int;

endmodule

// File: tb/tb_de10lite_gsensor_spi_responder.sv
// Scoreboard bench for de10lite_gsensor_spi_responder: SPI mode-3 master, register-map model, byte monitor.
`timescale 1ns/1ps
module tb_de10lite_gsensor_spi_responder;
    localparam int H = 6;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        sclk = 1'b1, cs_n = 1'b1, sdi = 1'b0;
    logic        sdo, sdo_oe, axis_valid = 1'b0;
    logic [1:0]  int_o;
    logic [15:0] ax = '0, ay = '0, az = '0;

    int          n_vec = 0, n_err = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  m_reg[64];
    bit          m_dr, m_pend_v;
    logic [15:0] m_pend[3];

    always #10 clk = ~clk;

    de10lite_gsensor_spi_responder dut (
        .clk_i(clk), .rst_ni(rst_n), .sclk_i(sclk), .cs_ni(cs_n), .sdi_i(sdi),
        .sdo_o(sdo), .sdo_oe_o(sdo_oe), .int_o(int_o),
        .axis_x_i(ax), .axis_y_i(ay), .axis_z_i(az), .axis_valid_i(axis_valid)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: assembles bytes the master samples on SCLK rise while SDO is driven
    initial begin : monitor
        logic [7:0] sh;
        int cnt;
        sh = '0;
        cnt = 0;
        forever begin
            @(posedge sclk or posedge cs_n);
            if (cs_n) cnt = 0;
            else if (sdo_oe) begin
                sh = {sh[6:0], sdo};
                cnt++;
                if (cnt == 8) begin
                    cnt = 0;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_byte: got %h with nothing expected", sh);
                    end else begin
                        chk("rd_byte", {8'h00, sh}, {8'h00, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic bit writable(input int a);
        if (a inside {'h2C, 'h2D, 'h2E, 'h2F, 'h31}) return 1'b1;
`ifdef GSENSOR_OFFSET_EN
        if (a inside {'h1E, 'h1F, 'h20}) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [7:0] m_read(input int a);
        if (a == 'h00) return 8'hE5;
        if (a == 'h30) return {m_dr, 7'b0};
        return m_reg[a];
    endfunction

    task automatic m_latch(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        logic [15:0] v[3];
        int sum;
        v = '{x, y, z};
        for (int i = 0; i < 3; i++) begin
            sum = int'(v[i]);
`ifdef GSENSOR_OFFSET_EN
            sum = sum + 4 * int'($signed(m_reg['h1E + i]));
`endif
            m_reg['h32 + 2*i] = 8'(sum);
            m_reg['h33 + 2*i] = 8'(sum >> 8);
        end
        m_dr = 1'b1;
    endtask

    task automatic strobe(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        @(negedge clk);
        ax = x; ay = y; az = z; axis_valid = 1'b1;
        @(negedge clk);
        axis_valid = 1'b0;
        if (m_reg['h2D][3]) begin
            if (cs_n) m_latch(x, y, z);
            else begin
                m_pend = '{x, y, z};
                m_pend_v = 1'b1;
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            @(negedge clk);
            sclk = 1'b0;
            sdi = tx[i];
            repeat (H) @(negedge clk);
            sclk = 1'b1;
            repeat (H - 1) @(negedge clk);
        end
    endtask

    task automatic cs_lo();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (H) @(negedge clk);
    endtask

    task automatic cs_hi();
        @(negedge clk);
        cs_n = 1'b1;
        repeat (2*H) @(negedge clk);
        if (m_pend_v) begin
            m_latch(m_pend[0], m_pend[1], m_pend[2]);
            m_pend_v = 1'b0;
        end
        chk("oe_idle", {15'd0, sdo_oe}, 16'd0);
    endtask

    task automatic spi_write(input int a, input logic [7:0] d, input int nbits);
        cs_lo();
        xfer({2'b00, 6'(a)}, 8);
        xfer(d, nbits);
        chk("oe_write", {15'd0, sdo_oe}, 16'd0);
        if (nbits == 8 && writable(a)) m_reg[a] = d;
        cs_hi();
    endtask

    task automatic spi_read(input int a0, input int n, input bit mb, input int strobe_at,
                            input logic [15:0] sx);
        int a;
        a = a0;
        cs_lo();
        chk("oe_cmd", {15'd0, sdo_oe}, 16'd0);
        xfer({1'b1, mb, 6'(a)}, 8);
        chk("oe_read", {15'd0, sdo_oe}, 16'd1);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(m_read(a));
            xfer(8'($urandom), 8);
            if (a == 'h37) m_dr = 1'b0;
            if (mb) a = (a + 1) % 64;
            if (k == strobe_at) strobe(sx, 16'($urandom), 16'($urandom));
        end
        cs_hi();
    endtask

    task automatic chk_int();
        logic [1:0] e;
        repeat (3) @(negedge clk);
        e = {m_dr & m_reg['h2E][7] & m_reg['h2F][7], m_dr & m_reg['h2E][7] & ~m_reg['h2F][7]};
        chk("int_o", {14'd0, int_o}, {14'd0, e});
    endtask

    initial begin
        int op, a, wlist[10];
        wlist = '{'h00, 'h1E, 'h2C, 'h2D, 'h2E, 'h2F, 'h30, 'h31, 'h32, 'h3A};
        for (int i = 0; i < 64; i++) m_reg[i] = 8'h00;
        m_reg['h2C] = 8'h0A;
        m_dr = 1'b0;
        m_pend_v = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_sdo", {15'd0, sdo}, 16'd0);
        chk("rst_oe", {15'd0, sdo_oe}, 16'd0);
        chk("rst_int", {14'd0, int_o}, 16'd0);

        spi_read('h00, 1, 1'b0, -1, 16'h0);
        spi_read('h2C, 1, 1'b0, -1, 16'h0);
        chk_int();

        spi_write('h2D, 8'h08, 8);
        spi_write('h2E, 8'h80, 8);
        strobe(16'h1234, 16'hFFFE, 16'h0100);
        chk_int();
        chk("int_int1", {14'd0, int_o}, 16'h0001);
        spi_read('h32, 6, 1'b1, -1, 16'h0);
        chk_int();
        chk("int_cleared", {14'd0, int_o}, 16'h0000);

        spi_write('h2F, 8'h80, 8);
        strobe(16'h0042, 16'h0043, 16'h0044);
        chk_int();
        chk("int_int2", {14'd0, int_o}, 16'h0002);
        spi_write('h2D, 8'h00, 8);
        strobe(16'h7777, 16'h8888, 16'h9999);
        chk_int();
        spi_read('h32, 2, 1'b1, -1, 16'h0);
        spi_write('h2D, 8'h08, 8);

        spi_read('h32, 2, 1'b0, 0, 16'h0005);
        spi_read('h32, 1, 1'b0, -1, 16'h0);
        chk_int();

        spi_write('h31, 8'hAB, 5);
        spi_read('h31, 1, 1'b0, -1, 16'h0);
        spi_read('h3F, 2, 1'b1, -1, 16'h0);

        spi_write('h1E, 8'hFF, 8);
        strobe(16'h0000, 16'h0000, 16'h0000);
        spi_read('h32, 2, 1'b1, -1, 16'h0);
        spi_write('h1E, 8'h7F, 8);
        spi_read('h1E, 1, 1'b0, -1, 16'h0);
        chk_int();

        for (int it = 0; it < 30; it++) begin
            op = int'($urandom_range(0, 3));
            case (op)
                0: begin
                    a = wlist[$urandom_range(0, 9)];
                    spi_write(a, 8'($urandom), 8);
                end
                1: spi_read(int'($urandom_range(0, 63)), int'($urandom_range(1, 4)),
                            1'($urandom), -1, 16'h0);
                2: strobe(16'($urandom), 16'($urandom), 16'($urandom));
                default: spi_read('h30, int'($urandom_range(1, 8)), 1'b1,
                                  int'($urandom_range(0, 3)), 16'($urandom));
            endcase
            chk_int();
        end

        chk("exp_q_drained", 16'(exp_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
